// File: rtl/frame_scan_controller.sv
// Frame scan controller for the edge-detection frame buffer.
// It runs one frame in two phases. CAPTURE writes camera pixels in row-major
// order. SCAN then reads every interior 3x3 window for the Sobel stage, one
// cycle after each issue. The block also counts camera pixels that arrive
// outside CAPTURE.
module frame_scan_controller #(
  parameter int WIDTH   = 768,
  parameter int HEIGHT  = 512,
  parameter int COORD_W = 11,
  parameter int DROP_W  = 16
) (
  input  logic               CAMERA_CLK,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               pix_valid,
  input  logic               win_ready,
  output logic               readWrite,
  output logic [COORD_W-1:0] coordinate_X,
  output logic [COORD_W-1:0] coordinate_Y,
  output logic               win_valid,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic               busy,
  output logic               frame_done,
  output logic [DROP_W-1:0]  dropped_pix,
  output logic [1:0]         state_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_SCAN    = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  // Last full-frame coordinates and last interior coordinates.
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] XI_LAST = COORD_W'(HEIGHT - 2);
  localparam logic [COORD_W-1:0] YI_LAST = COORD_W'(WIDTH - 2);
  localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
  localparam logic [DROP_W-1:0]  D_ONE   = DROP_W'(1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       pix_acc;
  logic       issue;
  logic       cap_last;
  logic       scan_last;

  assign pix_acc   = (state == S_CAPTURE) && pix_valid;
  assign issue     = (state == S_SCAN) && win_ready;
  assign cap_last  = pix_acc && (coordinate_X == X_LAST) && (coordinate_Y == Y_LAST);
  assign scan_last = issue && (coordinate_X == XI_LAST) && (coordinate_Y == YI_LAST);

  // State register.
  always_ff @(posedge CAMERA_CLK or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. abort overrides everything, including start in IDLE.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start)     state_nxt = S_CAPTURE;
        S_CAPTURE: if (cap_last)  state_nxt = S_SCAN;
        S_SCAN:    if (scan_last) state_nxt = S_DRAIN;
        default:                  state_nxt = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs. readWrite follows pix_valid with no register so
  // that a camera pixel is written in the same cycle it arrives.
  always_comb begin
    readWrite  = pix_acc;
    busy       = (state != S_IDLE);
    frame_done = (state == S_DRAIN);
    state_o    = state;
  end

  // Buffer coordinates. CAPTURE walks the full frame; SCAN walks the interior only.
  always_ff @(posedge CAMERA_CLK or posedge rst) begin
    if (rst) begin
      coordinate_X <= '0;
      coordinate_Y <= '0;
    end else if (state_nxt == S_IDLE) begin
      coordinate_X <= '0;
      coordinate_Y <= '0;
    end else if (cap_last) begin
      coordinate_X <= C_ONE;
      coordinate_Y <= C_ONE;
    end else if (pix_acc) begin
      if (coordinate_Y == Y_LAST) begin
        coordinate_Y <= '0;
        coordinate_X <= coordinate_X + C_ONE;
      end else begin
        coordinate_Y <= coordinate_Y + C_ONE;
      end
    end else if (issue) begin
      if (coordinate_Y == YI_LAST) begin
        coordinate_Y <= C_ONE;
        coordinate_X <= coordinate_X + C_ONE;
      end else begin
        coordinate_Y <= coordinate_Y + C_ONE;
      end
    end
  end

  // Window tag: one-cycle-delayed copy of each issue. An abort discards the window.
  always_ff @(posedge CAMERA_CLK or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
    end else begin
      win_valid <= issue && !abort;
      if (issue) begin
        win_x <= coordinate_X;
        win_y <= coordinate_Y;
      end
    end
  end

  // Saturating count of camera pixels that arrive while the buffer is not capturing.
  always_ff @(posedge CAMERA_CLK or posedge rst) begin
    if (rst) begin
      dropped_pix <= '0;
    end else if (pix_valid && (state != S_CAPTURE) && (dropped_pix != '1)) begin
      dropped_pix <= dropped_pix + D_ONE;
    end
  end

endmodule

// File: tb/tb_frame_scan_controller.sv
// Bench for frame_scan_controller on a 4x3 image. The bench keeps a
// frame-level model that tracks pixel and window ordinals. A second instance
// with a 2-bit drop counter shares the same stimulus so that counter
// saturation can be observed.
module tb_frame_scan_controller;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 11;

  logic CAMERA_CLK = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, pix_valid = 1'b0, win_ready = 1'b0;

  logic          readWrite, win_valid, busy, frame_done;
  logic [CW-1:0] coordinate_X, coordinate_Y, win_x, win_y;
  logic [15:0]   dropped_pix;
  logic [1:0]    state_o;

  logic          s_readWrite, s_win_valid, s_busy, s_frame_done;
  logic [CW-1:0] s_cx, s_cy, s_wx, s_wy;
  logic [1:0]    s_dropped, s_state;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0, wv_cnt = 0, fd_cnt = 0;

  // Model state: phase, pixels accepted this frame, windows issued this frame.
  int m_state = 0, m_pix = 0, m_win = 0, m_drop = 0;
  int m_wv = 0, m_wx = 0, m_wy = 0, m_ns = 0;

  frame_scan_controller #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .DROP_W(16)) dut (
    .CAMERA_CLK(CAMERA_CLK), .rst(rst), .start(start), .abort(abort),
    .pix_valid(pix_valid), .win_ready(win_ready), .readWrite(readWrite),
    .coordinate_X(coordinate_X), .coordinate_Y(coordinate_Y),
    .win_valid(win_valid), .win_x(win_x), .win_y(win_y), .busy(busy),
    .frame_done(frame_done), .dropped_pix(dropped_pix), .state_o(state_o)
  );

  frame_scan_controller #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .DROP_W(2)) u_sat (
    .CAMERA_CLK(CAMERA_CLK), .rst(rst), .start(start), .abort(abort),
    .pix_valid(pix_valid), .win_ready(win_ready), .readWrite(s_readWrite),
    .coordinate_X(s_cx), .coordinate_Y(s_cy),
    .win_valid(s_win_valid), .win_x(s_wx), .win_y(s_wy), .busy(s_busy),
    .frame_done(s_frame_done), .dropped_pix(s_dropped), .state_o(s_state)
  );

  always #5 CAMERA_CLK = ~CAMERA_CLK;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_x();
    if (m_state == 1) return m_pix / W;
    if (m_state == 2) return 1 + m_win / (W - 2);
    return 0;
  endfunction

  function automatic int exp_y();
    if (m_state == 1) return m_pix % W;
    if (m_state == 2) return 1 + m_win % (W - 2);
    return 0;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Frame-level model: advance the phase and the ordinals from the inputs seen at each edge.
  always @(posedge CAMERA_CLK or posedge rst) begin
    if (rst) begin
      m_state = 0; m_pix = 0; m_win = 0; m_drop = 0;
      m_wv = 0; m_wx = 0; m_wy = 0;
    end else begin
      m_ns = m_state;
      if (pix_valid && m_state != 1) m_drop++;
      m_wv = (m_state == 2 && win_ready && !abort) ? 1 : 0;
      if (m_state == 2 && win_ready) begin
        m_wx = exp_x();
        m_wy = exp_y();
      end
      if (abort) begin
        m_ns = 0;
      end else begin
        case (m_state)
          0: if (start) begin m_ns = 1; m_pix = 0; end
          1: if (pix_valid) begin
               m_pix++;
               if (m_pix == W * H) begin m_ns = 2; m_win = 0; end
             end
          2: if (win_ready) begin
               m_win++;
               if (m_win == (W - 2) * (H - 2)) m_ns = 3;
             end
          default: m_ns = 0;
        endcase
      end
      if (m_ns == 0) begin m_pix = 0; m_win = 0; end
      m_state = m_ns;
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge CAMERA_CLK) begin
    chk("state", int'(state_o), m_state);
    chk("busy", int'(busy), (m_state != 0) ? 1 : 0);
    chk("readWrite", int'(readWrite), (m_state == 1) ? int'(pix_valid) : 0);
    chk("frame_done", int'(frame_done), (m_state == 3) ? 1 : 0);
    chk("win_valid", int'(win_valid), m_wv);
    if (m_wv != 0) begin
      chk("win_x", int'(win_x), m_wx);
      chk("win_y", int'(win_y), m_wy);
    end
    if (m_state != 3) begin
      chk("coord_X", int'(coordinate_X), exp_x());
      chk("coord_Y", int'(coordinate_Y), exp_y());
    end
    chk("dropped", int'(dropped_pix), sat(m_drop, 65535));
    chk("dropped_sat", int'(s_dropped), sat(m_drop, 3));
    wr_cnt += int'(readWrite);
    wv_cnt += int'(win_valid);
    fd_cnt += int'(frame_done);
  end

  task automatic step();
    @(posedge CAMERA_CLK);
    #1;
  endtask

  task automatic capture_burst();
    start = 1'b1; step(); start = 1'b0;
    pix_valid = 1'b1;
    repeat (W * H) step();
    pix_valid = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    step(); step();
    chk("rst_state", int'(state_o), 0);
    chk("rst_coordX", int'(coordinate_X), 0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_dropped", int'(dropped_pix), 0);
    rst = 1'b0;
    step();

    // Contiguous capture, then a full scan with win_ready held high.
    wr_cnt = 0;
    capture_burst();
    chk("cap_writes", wr_cnt, 12);
    chk("cap_to_scan", int'(state_o), 2);
    chk("scan_X0", int'(coordinate_X), 1);
    chk("scan_Y0", int'(coordinate_Y), 1);
    fd_cnt = 0;
    win_ready = 1'b1;
    step();
    chk("win1_valid", int'(win_valid), 1);
    chk("win1_x", int'(win_x), 1);
    chk("win1_y", int'(win_y), 1);
    step();
    win_ready = 1'b0;
    chk("drain_state", int'(state_o), 3);
    chk("win2_y", int'(win_y), 2);
    chk("drain_done", int'(frame_done), 1);
    step();
    chk("after_drain", int'(state_o), 0);
    chk("done_pulses", fd_cnt, 1);

    // Capture with a gap after every pixel, then a scan with ready 1,0,0,1.
    wr_cnt = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < W * H; i++) begin
      pix_valid = 1'b1; step();
      pix_valid = 1'b0; step();
    end
    chk("gap_writes", wr_cnt, 12);
    chk("gap_scan", int'(state_o), 2);
    wv_cnt = 0;
    win_ready = 1'b1; step();
    win_ready = 1'b0; step(); step();
    chk("hold_Y", int'(coordinate_Y), 2);
    win_ready = 1'b1; step();
    win_ready = 1'b0; step();
    chk("toggle_pulses", wv_cnt, 2);
    chk("toggle_idle", int'(state_o), 0);

    // Dropped pixels: 5 in IDLE and 3 in SCAN.
    pix_valid = 1'b1; repeat (5) step(); pix_valid = 1'b0;
    capture_burst();
    pix_valid = 1'b1; repeat (3) step(); pix_valid = 1'b0;
    chk("dropped8", int'(dropped_pix), 8);
    chk("dropped_sat3", int'(s_dropped), 3);
    win_ready = 1'b1; step(); step(); win_ready = 1'b0;
    step();

    // Abort in the cycle after an issue, while a second issue is offered.
    fd_cnt = 0;
    capture_burst();
    win_ready = 1'b1; step();
    abort = 1'b1; step();
    abort = 1'b0; win_ready = 1'b0;
    chk("abort_state", int'(state_o), 0);
    chk("abort_win_valid", int'(win_valid), 0);
    step();
    chk("abort_no_done", fd_cnt, 0);

    // start together with abort in IDLE stays in IDLE.
    start = 1'b1; abort = 1'b1; step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort", int'(state_o), 0);

    // Asynchronous reset in the middle of a capture.
    start = 1'b1; step(); start = 1'b0;
    pix_valid = 1'b1; repeat (5) step(); pix_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(state_o), 0);
    chk("arst_coordY", int'(coordinate_Y), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_dropped", int'(dropped_pix), 0);
    step();
    rst = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_scan_controller.md
Name: frame_scan_controller

Overview:
- Sequences the edge-detection frame buffer through one frame: a CAPTURE phase that writes camera pixels, then a SCAN phase that reads every interior 3x3 window for the Sobel stage.
- Generates the buffer's readWrite, coordinate_X and coordinate_Y, and tags returned windows with valid and coordinates.
- Applies downstream backpressure and reports frame completion and dropped pixels.
- Sits between the camera interface, frameBuffer2 and the Sobel filter.

Parameters:
- WIDTH, 768, image width in pixels; column index range 0..WIDTH-1.
- HEIGHT, 512, image height in pixels; row index range 0..HEIGHT-1.
- COORD_W, 11, width of coordinate buses.
- DROP_W, 16, width of the dropped-pixel counter.

Ports:
- CAMERA_CLK  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  synchronous return to IDLE from any state.
- pix_valid  in  1  camera pixel present this cycle.
- win_ready  in  1  Sobel stage can take a window one cycle later.
- readWrite  out  1  to buffer; 1 = write pixel, 0 = read window.
- coordinate_X  out  COORD_W  to buffer; row index.
- coordinate_Y  out  COORD_W  to buffer; column index.
- win_valid  out  1  buffer window outputs valid this cycle.
- win_x  out  COORD_W  row of the centre pixel of the valid window.
- win_y  out  COORD_W  column of the centre pixel of the valid window.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse at end of SCAN.
- dropped_pix  out  DROP_W  saturating count of pix_valid outside CAPTURE.
- state_o  out  2  IDLE=0, CAPTURE=1, SCAN=2, DRAIN=3.

Behaviour:
- Reset (async, active-high): state IDLE.
  - coordinate_X = 0, coordinate_Y = 0.
  - win_valid, win_x, win_y, frame_done, dropped_pix = 0.
  - readWrite = 0.
- Coordinates are registered outputs. Row-major traversal: Y (column) is inner, X (row) is outer.
- IDLE: on start=1, go to CAPTURE with coordinates (0,0).
- CAPTURE:
  - readWrite = pix_valid. This is the only combinational output path.
  - On each pix_valid, the current (X,Y) is written.
    - Next cycle, Y increments.
    - When Y = WIDTH-1, Y wraps to 0 and X increments.
  - Cycles without pix_valid hold the coordinates; gaps are unlimited.
  - The accepted pixel at (HEIGHT-1, WIDTH-1) causes the next state to be SCAN with coordinates (1,1).
- SCAN:
  - readWrite = 0.
  - issue = win_ready. On issue, the current (X,Y) is read.
  - Coordinates advance over interior pixels only: Y runs 1..WIDTH-2, then wraps to 1 and X increments. X runs 1..HEIGHT-2.
  - Without win_ready, the coordinates hold.
  - Issue of (HEIGHT-2, WIDTH-2) causes the next state to be DRAIN.
- Read latency is 1 cycle. win_valid, win_x and win_y are registered copies of issue and the issued coordinates. win_valid is high exactly the cycle after each issue.
- DRAIN: lasts one cycle. It carries the final win_valid, asserts frame_done, then returns to IDLE with coordinates (0,0).
- Windows per frame = (HEIGHT-2)*(WIDTH-2). Border pixels are never issued, so the buffer never sees X-1 or Y-1 underflow.
- dropped_pix:
  - Increments on pix_valid in IDLE, SCAN or DRAIN.
  - Saturates at 2^DROP_W-1.
  - Cleared only by rst.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins, and the state stays IDLE.
- abort:
  - Next state IDLE, coordinates (0,0).
  - win_valid = 0 next cycle; any in-flight window is discarded.
  - No frame_done.
- Reset mid-frame: immediate return to reset values; the frame is discarded.
- WIDTH and HEIGHT must each be ≥3 and fit in COORD_W bits. Any other value is illegal configuration.

Test Plan:
- WIDTH=4, HEIGHT=3; start, then 12 consecutive pix_valid -> readWrite high 12 cycles; coordinates (0,0),(0,1)..(2,3); state SCAN with coordinates (1,1).
- Continue with win_ready=1 -> issues (1,1),(1,2); win_valid on the next two cycles with win_x/win_y = (1,1),(1,2); frame_done pulses once in DRAIN; IDLE after.
- Capture with pix_valid on alternate cycles -> coordinates hold during gaps; still 12 writes; SCAN entered after 12th pixel.
- SCAN with win_ready toggling 1,0,0,1 -> exactly 2 win_valid pulses, each one cycle after a ready=1 cycle; coordinates unchanged while ready=0.
- pix_valid pulsed 5 times in IDLE and 3 times in SCAN -> dropped_pix=8; with DROP_W=2, it saturates at 3.
- abort in the cycle after an issue -> win_valid=0 next cycle, IDLE, no frame_done. Assert rst mid-CAPTURE -> outputs return to reset values immediately, without waiting for a CAMERA_CLK edge.
